// File: rtl/jk_updown_counter.sv
// jk_updown_counter: WIDTH-bit synchronous up/down counter built from a row
// of JK cells. Each cell's J/K pair comes from load, enable, direction and
// the toggle chain of the lower bits.
// Optional build macro: JK_CNT_SAT_EN (saturate at terminal count instead of
// wrapping; the wrap pulse then stays low).
module jk_updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EN,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic [WIDTH-1:0] toggleUp;
  logic [WIDTH-1:0] toggleDown;
  logic [WIDTH-1:0] cellJ;
  logic [WIDTH-1:0] cellK;
  logic             upRun;
  logic             downRun;

  // Toggle chains: bit i flips when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    toggleUp   = '0;
    toggleDown = '0;
    upRun      = 1'b1;
    downRun    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      toggleUp[i]   = upRun;
      toggleDown[i] = downRun;
      upRun         = upRun & count_q[i];
      downRun       = downRun & ~count_q[i];
    end
  end

  // Terminal count: enabled, not loading, and sitting at the end of the range.
  always_comb begin
    tc = EN & ~load & (up ? (&count_q) : ~(|count_q));
  end

  // J/K generation: load forces set/clear per bit, counting drives J=K=T.
  always_comb begin
    cellJ = '0;
    cellK = '0;
    if (load) begin
      cellJ = d;
      cellK = ~d;
    end else if (EN) begin
`ifdef JK_CNT_SAT_EN
      if (!tc) begin
        cellJ = up ? toggleUp : toggleDown;
        cellK = up ? toggleUp : toggleDown;
      end
`else
      cellJ = up ? toggleUp : toggleDown;
      cellK = up ? toggleUp : toggleDown;
`endif
    end
  end

  // JK cell rule per bit, plus the wrap pulse request for the next cycle.
  always_comb begin
    count_d = count_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({cellJ[i], cellK[i]})
        2'b00:   count_d[i] = count_q[i];
        2'b10:   count_d[i] = 1'b1;
        2'b01:   count_d[i] = 1'b0;
        default: count_d[i] = ~count_q[i];
      endcase
    end
`ifdef JK_CNT_SAT_EN
    wrap_d = 1'b0;
`else
    wrap_d = tc;
`endif
  end

  // State register with synchronous reset clearing count and wrap pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q    = count_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_updown_counter.sv
// tb_jk_updown_counter: directed vector table plus randomized run against an
// arithmetic reference model of the up/down counter.
module tb_jk_updown_counter;

  localparam int WIDTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  typedef struct {
    logic             rst;
    logic             en;
    logic             up;
    logic             ld;
    logic [WIDTH-1:0] d;
    logic             expTc;
    logic [WIDTH-1:0] expQ;
    logic             expWrap;
  } vec_t;

  logic             clk;
  logic             reset;
  logic             EN;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  int passCount;
  int totalCount;
  int modelQ;
  int modelWrap;
  vec_t vecs[$];

  jk_updown_counter #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .EN   (EN),
    .up   (up),
    .load (load),
    .d    (d),
    .q    (q),
    .tc   (tc),
    .wrap (wrap)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    else
      passCount++;
  endtask

  task automatic addVec(input logic rst, input logic en, input logic upDir, input logic ld,
                        input int dv, input logic eTc, input int eQ, input logic eWrap);
    vec_t v;
    v.rst = rst; v.en = en; v.up = upDir; v.ld = ld; v.d = dv[WIDTH-1:0];
    v.expTc = eTc; v.expQ = eQ[WIDTH-1:0]; v.expWrap = eWrap;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    reset = v.rst; EN = v.en; up = v.up; load = v.ld; d = v.d;
    #1;
    checkOutput($sformatf("vec%0d tc", idx), int'(tc), int'(v.expTc));
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d q", idx), int'(q), int'(v.expQ));
    checkOutput($sformatf("vec%0d wrap", idx), int'(wrap), int'(v.expWrap));
  endtask

  function automatic int modelTc(input logic en, input logic upDir, input logic ld, input int cur);
    if (!en || ld) return 0;
    return upDir ? int'(cur == MAXV) : int'(cur == 0);
  endfunction

  // Reference model step: plain modulo arithmetic with optional saturation.
  task automatic modelStep(input logic rst, input logic en, input logic upDir,
                           input logic ld, input int dv);
    int atEnd;
    atEnd = modelTc(en, upDir, ld, modelQ);
    modelWrap = 0;
    if (rst) begin
      modelQ = 0;
    end else if (ld) begin
      modelQ = dv;
    end else if (en) begin
`ifdef JK_CNT_SAT_EN
      if (atEnd == 0) modelQ = upDir ? modelQ + 1 : modelQ - 1;
`else
      modelQ = (upDir ? modelQ + 1 : modelQ - 1 + (MAXV + 1)) % (MAXV + 1);
      modelWrap = atEnd;
`endif
    end
  endtask

  initial begin
    passCount = 0;
    totalCount = 0;
    reset = 1'b0; EN = 1'b0; up = 1'b0; load = 1'b0; d = '0;

    // Reset, load 5, reset again from 5
    addVec(1, 0, 0, 0, 0, 0, 0, 0);
    addVec(0, 0, 0, 1, 5, 0, 5, 0);
    addVec(1, 0, 0, 0, 0, 0, 0, 0);
`ifdef JK_CNT_SAT_EN
    addVec(0, 0, 0, 1, 15, 0, 15, 0);
    for (int k = 0; k < 3; k++) addVec(0, 1, 1, 0, 0, 1, 15, 0);
    addVec(0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) addVec(0, 1, 0, 0, 0, 1, 0, 0);
`else
    // Count up 15 edges, then roll over with a single-cycle wrap pulse
    for (int k = 0; k < 15; k++) addVec(0, 1, 1, 0, 0, 0, k + 1, 0);
    addVec(0, 1, 1, 0, 0, 1, 0, 1);
    addVec(0, 0, 1, 0, 0, 0, 0, 0);
    // Down from 0 wraps to 15, then 14
    addVec(0, 1, 0, 0, 0, 1, 15, 1);
    addVec(0, 1, 0, 0, 0, 0, 14, 0);
`endif
    // Load 9 with EN set, then hold for 5 edges
    addVec(0, 1, 1, 1, 9, 0, 9, 0);
    for (int k = 0; k < 5; k++) addVec(0, 0, 1, 0, 0, 0, 9, 0);
    // Reset wins over load at q=7
    addVec(0, 0, 1, 1, 7, 0, 7, 0);
    addVec(1, 1, 1, 1, 3, 0, 0, 0);
    // Load at all-ones with EN never wraps
    addVec(0, 0, 1, 1, 15, 0, 15, 0);
    addVec(0, 1, 1, 1, 2, 0, 2, 0);
    // Reset with EN at terminal count clears wrap too
    addVec(0, 0, 1, 1, 15, 0, 15, 0);
    addVec(1, 1, 1, 0, 0, 1, 0, 0);
    // Direction toggled every edge from 4
    addVec(0, 0, 1, 1, 4, 0, 4, 0);
    addVec(0, 1, 1, 0, 0, 0, 5, 0);
    addVec(0, 1, 0, 0, 0, 0, 4, 0);
    addVec(0, 1, 1, 0, 0, 0, 5, 0);
    addVec(0, 1, 0, 0, 0, 0, 4, 0);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // Randomized run against the reference model, starting from reset
    @(negedge clk);
    reset = 1'b1; EN = 1'b0; load = 1'b0;
    @(posedge clk);
    modelQ = 0;
    modelWrap = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 40) == 0);
      load  = ($urandom_range(0, 9) == 0);
      EN    = ($urandom_range(0, 4) != 0);
      up    = ($urandom_range(0, 5) != 0) ? (n / 40) % 2 == 0 : $urandom_range(0, 1) == 1;
      d     = WIDTH'($urandom_range(0, MAXV));
      #1;
      checkOutput($sformatf("rand%0d tc", n), int'(tc), modelTc(EN, up, load, modelQ));
      modelStep(reset, EN, up, load, int'(d));
      @(posedge clk);
      #1;
      checkOutput($sformatf("rand%0d q", n), int'(q), modelQ);
      checkOutput($sformatf("rand%0d wrap", n), int'(wrap), modelWrap);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
